patgen_multi: RTL and testbench

PATGEN_MULTI -- requirements
Module: patgen_multi

---
 rtl/patgen_multi_if.sv | 24 ++
 rtl/patgen_multi.sv | 146 ++++++++++++++
 tb/tb_patgen_multi.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/patgen_multi_if.sv
// Display-side signal bundle for the multi-pattern test generator.
// The generator sits on the slave side: it consumes timing/control and returns video.
interface patgen_multi_if #(
  parameter int CW = 8
);
  logic          DSP_preDE;
  logic          DSP_VSYNC_X;
  logic [2:0]    MODE;
  logic          SCROLL_EN;
  logic          DSP_DE;
  logic [CW-1:0] DSP_R;
  logic [CW-1:0] DSP_G;
  logic [CW-1:0] DSP_B;

  modport master (
    output DSP_preDE, DSP_VSYNC_X, MODE, SCROLL_EN,
    input  DSP_DE, DSP_R, DSP_G, DSP_B
  );

  modport slave (
    input  DSP_preDE, DSP_VSYNC_X, MODE, SCROLL_EN,
    output DSP_DE, DSP_R, DSP_G, DSP_B
  );
endinterface

// File: rtl/patgen_multi.sv
// Multi-pattern video test generator: colour bars, checker, gradient, crosshatch and solids.
// Pixel/line/frame counters track the pre-DE strobe; video is registered one cycle later.
module patgen_multi #(
  parameter int CW     = 8,
  parameter int HDO    = 640,
  parameter int VDO    = 480,
  parameter int NBARS  = 8,
  parameter int CHKLOG = 5
) (
  input  logic           DCLK,
  input  logic           DRST,
  patgen_multi_if.slave  bus
);

  localparam int            BW    = HDO / NBARS;
  localparam logic [10:0]   XMAX  = 11'(HDO - 1);
  localparam logic [10:0]   YMAX  = 11'(VDO - 1);
  localparam logic [10:0]   PMAX  = 11'(BW - 1);
  localparam logic [2:0]    BMASK = 3'(NBARS - 1);
  localparam logic [2:0]    STEP  = 3'(8 / NBARS);
  localparam logic [CW-1:0] ONES  = {CW{1'b1}};

  logic [10:0]   r_x;
  logic [10:0]   r_y;
  logic [10:0]   r_p;
  logic [2:0]    r_b;
  logic [10:0]   r_f;
  logic [2:0]    r_mode;
  logic          r_vsD;
  logic          r_preDeD;
  logic          r_de;
  logic [CW-1:0] r_red;
  logic [CW-1:0] r_green;
  logic [CW-1:0] r_blue;

  logic          w_frameStart;
  logic          w_preFall;
  logic [10:0]   w_xf;
  logic [10:0]   w_checker;
  logic [2:0]    w_barIdx;
  logic [2:0]    w_barCode;
  logic          w_cross;
  logic [CW-1:0] w_red;
  logic [CW-1:0] w_green;
  logic [CW-1:0] w_blue;

  assign w_frameStart = r_vsD & ~bus.DSP_VSYNC_X;
  assign w_preFall    = r_preDeD & ~bus.DSP_preDE;

  // Scroll offset f shifts bars, checker columns and gradient; crosshatch stays put.
  assign w_xf      = r_x + r_f;
  assign w_checker = ((w_xf >> CHKLOG) ^ (r_y >> CHKLOG)) & 11'd1;
  assign w_barIdx  = (r_b + r_f[2:0]) & BMASK;
  assign w_barCode = 3'd7 - 3'(w_barIdx * STEP);
  assign w_cross   = (r_x[3:0] == 4'd0) || (r_y[3:0] == 4'd0) ||
                     (r_x == XMAX) || (r_y == YMAX);

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    if (bus.DSP_preDE) begin
      case (r_mode)
        3'd0: begin
          w_red   = {CW{w_barCode[1]}};
          w_green = {CW{w_barCode[2]}};
          w_blue  = {CW{w_barCode[0]}};
        end
        3'd1: begin
          w_red   = (w_checker == 11'd0) ? ONES : '0;
          w_green = w_red;
          w_blue  = w_red;
        end
        3'd2: begin
          w_red   = w_xf[CW-1:0];
          w_green = w_xf[CW-1:0];
          w_blue  = w_xf[CW-1:0];
        end
        3'd3: begin
          w_red   = w_cross ? ONES : '0;
          w_green = w_red;
          w_blue  = w_red;
        end
        3'd4: begin
          w_red   = ONES;
          w_green = ONES;
          w_blue  = ONES;
        end
        default: ;
      endcase
    end
  end

  // Counters describe the pixel currently on preDE; the bar index avoids a divider.
  always_ff @(posedge DCLK) begin
    if (DRST) begin
      r_x      <= '0;
      r_y      <= '0;
      r_p      <= '0;
      r_b      <= '0;
      r_f      <= '0;
      r_mode   <= '0;
      r_vsD    <= 1'b1;
      r_preDeD <= 1'b0;
      r_de     <= 1'b0;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
    end else begin
      r_vsD    <= bus.DSP_VSYNC_X;
      r_preDeD <= bus.DSP_preDE;
      r_de     <= bus.DSP_preDE;
      r_red    <= w_red;
      r_green  <= w_green;
      r_blue   <= w_blue;

      if (w_frameStart) begin
        r_mode <= bus.MODE;
        if (bus.SCROLL_EN) r_f <= r_f + 11'd1;
      end

      if (bus.DSP_preDE) begin
        if (r_x != XMAX) r_x <= r_x + 11'd1;
        if (r_p == PMAX) begin
          r_p <= '0;
          r_b <= r_b + 3'd1;
        end else begin
          r_p <= r_p + 11'd1;
        end
      end else if (r_preDeD) begin
        r_x <= '0;
        r_p <= '0;
        r_b <= '0;
      end

      if (w_frameStart) r_y <= '0;
      else if (w_preFall && (r_y != YMAX)) r_y <= r_y + 11'd1;
    end
  end

  assign bus.DSP_DE = r_de;
  assign bus.DSP_R  = r_red;
  assign bus.DSP_G  = r_green;
  assign bus.DSP_B  = r_blue;

endmodule

// File: tb/tb_patgen_multi.sv
// Bench for patgen_multi: directed scenarios plus randomized frames, every cycle
// compared with a pixel-coordinate reference model of the pattern rules.
module tb_patgen_multi;
  localparam int CW     = 8;
  localparam int HDO    = 640;
  localparam int VDO    = 480;
  localparam int NBARS  = 8;
  localparam int CHKLOG = 5;
  localparam int BW     = HDO / NBARS;
  localparam logic [31:0] WHITE = 32'h01ffffff;
  localparam logic [31:0] BLACK = 32'h01000000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  patgen_multi_if #(.CW(CW)) ifc ();

  patgen_multi #(.CW(CW), .HDO(HDO), .VDO(VDO), .NBARS(NBARS), .CHKLOG(CHKLOG)) dut (
    .DCLK (clock),
    .DRST (reset),
    .bus  (ifc)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [2:0] modeIn   = 3'd0;
  logic       scrollIn = 1'b0;

  int mF = 0, mMode = 0, mLine = 0, mPix = 0;
  bit mPrevPre = 1'b0, mPrevVs = 1'b1;

  logic [31:0] lineCap [0:799];
  logic [31:0] blankCap;
  logic [31:0] lastOut;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {DE,R,G,B} for an active pixel, straight from the pattern definitions.
  function automatic logic [31:0] refPixel(input int pix, input int line, input int f, input int mode);
    int x, y, bar, c, k, v;
    logic [7:0] r, g, b;
    x = (pix < HDO - 1) ? pix : HDO - 1;
    y = (line < VDO - 1) ? line : VDO - 1;
    bar = (pix / BW) % 8;
    r = 0; g = 0; b = 0;
    case (mode)
      0: begin
        c = 7 - ((bar + f) % NBARS) * (8 / NBARS);
        r = ((c & 2) != 0) ? 8'hff : 8'h00;
        g = ((c & 4) != 0) ? 8'hff : 8'h00;
        b = ((c & 1) != 0) ? 8'hff : 8'h00;
      end
      1: begin
        k = (((x + f) >> CHKLOG) ^ (y >> CHKLOG)) & 1;
        r = (k == 0) ? 8'hff : 8'h00; g = r; b = r;
      end
      2: begin
        v = (x + f) % (1 << CW);
        r = 8'(v); g = r; b = r;
      end
      3: begin
        if ((x % 16 == 0) || (y % 16 == 0) || (x == HDO - 1) || (y == VDO - 1)) r = 8'hff;
        g = r; b = r;
      end
      4: begin r = 8'hff; g = 8'hff; b = 8'hff; end
      default: ;
    endcase
    return {7'b0, 1'b1, r, g, b};
  endfunction

  task automatic applyStimulus(input logic rst, input logic pre, input logic vs);
    logic [31:0] exp;
    bit fs;
    reset           = rst;
    ifc.DSP_preDE   = pre;
    ifc.DSP_VSYNC_X = vs;
    ifc.MODE        = modeIn;
    ifc.SCROLL_EN   = scrollIn;
    @(posedge clock);
    #1;
    if (rst) begin
      exp = 32'h0;
      mF = 0; mMode = 0; mLine = 0; mPix = 0; mPrevPre = 0; mPrevVs = 1;
    end else begin
      fs  = mPrevVs && !vs;
      exp = pre ? refPixel(mPix, mLine, mF, mMode) : 32'h0;
      if (fs) begin
        mMode = int'(modeIn);
        if (scrollIn) mF = (mF + 1) % 2048;
        mLine = 0;
      end else if (mPrevPre && !pre) begin
        mLine++;
      end
      if (pre) mPix++;
      else if (mPrevPre) mPix = 0;
      mPrevVs  = vs;
      mPrevPre = pre;
    end
    lastOut = {7'b0, ifc.DSP_DE, ifc.DSP_R, ifc.DSP_G, ifc.DSP_B};
    checkOutput("pix", lastOut, exp);
  endtask

  task automatic frameStart(input logic [2:0] m, input logic s);
    modeIn = m; scrollIn = s;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
  endtask

  task automatic runLine(input int len, input int blank, input int rstAt);
    for (int i = 0; i < len; i++) begin
      applyStimulus(i == rstAt, 1, 1);
      lineCap[i] = lastOut;
    end
    for (int i = 0; i < blank; i++) begin
      applyStimulus(0, 0, 1);
      if (i == 0) blankCap = lastOut;
    end
  endtask

  initial begin
    $display("[TB] start");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1);
    checkOutput("reset", lastOut, 32'h0);
    applyStimulus(0, 0, 1);

    // Colour bars, no scroll: every line identical.
    frameStart(3'd0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      runLine(HDO, 20, -1);
      checkOutput("bar0_first", lineCap[0], WHITE);
      checkOutput("bar0_last", lineCap[79], WHITE);
      checkOutput("bar1_first", lineCap[80], 32'h01ffff00);
      checkOutput("bar1_last", lineCap[159], 32'h01ffff00);
      checkOutput("bar7", lineCap[560], BLACK);
      checkOutput("bar7_end", lineCap[639], BLACK);
      checkOutput("blank_after", blankCap, 32'h0);
    end

    // Gradient with scroll over three frames.
    for (int n = 1; n <= 3; n++) begin
      frameStart(3'd2, 1'b1);
      for (int l = 0; l < 2; l++) begin
        runLine(300, 10, -1);
        checkOutput("grad_x10", lineCap[10], 32'h01000000 | (32'(10 + n) * 32'h010101));
        checkOutput("grad_x250", lineCap[250], 32'h01000000 | (32'((250 + n) % 256) * 32'h010101));
        checkOutput("grad_wrap", lineCap[255], 32'h01000000 | (32'(n - 1) * 32'h010101));
      end
    end

    // Mode change mid-frame stays hidden until the next frame start (f is 3 here).
    frameStart(3'd0, 1'b0);
    runLine(100, 5, -1);
    modeIn = 3'd1;
    for (int l = 0; l < 3; l++) begin
      runLine(100, 5, -1);
      checkOutput("mode_hold", lineCap[0], 32'h0100ff00);
    end
    frameStart(3'd1, 1'b0);
    for (int l = 0; l < 34; l++) begin
      runLine(40, 4, -1);
      if (l == 0) begin
        checkOutput("chk_0_0", lineCap[0], WHITE);
        checkOutput("chk_32_0", lineCap[32], BLACK);
      end
      if (l == 32) checkOutput("chk_32_32", lineCap[32], WHITE);
    end

    // Crosshatch with an over-long line: x saturates at HDO-1.
    frameStart(3'd3, 1'b0);
    runLine(20, 5, -1);
    runLine(700, 10, -1);
    checkOutput("cross_x5", lineCap[5], BLACK);
    checkOutput("cross_x16", lineCap[16], WHITE);
    checkOutput("cross_x638", lineCap[638], BLACK);
    checkOutput("sat_640", lineCap[640], WHITE);
    checkOutput("sat_699", lineCap[699], WHITE);

    // One-cycle reset mid-line: back to bars, f=0, counters from zero.
    frameStart(3'd2, 1'b1);
    runLine(400, 10, 300);
    checkOutput("rst_de", lineCap[300], 32'h0);
    checkOutput("rst_next", lineCap[301], WHITE);
    checkOutput("rst_bar1", lineCap[381], 32'h01ffff00);
    runLine(100, 10, -1);
    checkOutput("rst_line2", lineCap[0], WHITE);

    // Randomized frames with mid-frame MODE noise and occasional resets.
    for (int fr = 0; fr < 20; fr++) begin
      int nl;
      frameStart(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) begin
        int len, ra;
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 700) : $urandom_range(1, 300);
        ra  = ($urandom_range(0, 25) == 0) ? $urandom_range(0, len - 1) : -1;
        if ($urandom_range(0, 2) == 0) modeIn = 3'($urandom_range(0, 7));
        runLine(len, $urandom_range(1, 12), ra);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
